// File: rtl/iodelay_cal.sv
// Input-delay calibration: sweeps every tap of an external delay line, finds the
// widest contiguous window where the lane matches the training pattern, and parks in its centre.
module iodelay_cal #(
   parameter int P_DATA_NBIT  = 1,
   parameter int P_DELAY_NBIT = 5,
   parameter int P_SETTLE     = 8,
   parameter int P_CHECK      = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_start,
   input  logic [P_DATA_NBIT-1:0]  in_pattern,
   input  logic [P_DATA_NBIT-1:0]  in_dio,
   output logic [P_DELAY_NBIT-1:0] out_delay,
   output logic                    out_delay_we,
   output logic                    out_busy,
   output logic                    out_done,
   output logic                    out_fail,
   output logic [P_DELAY_NBIT-1:0] out_win_start,
   output logic [P_DELAY_NBIT:0]   out_win_len
);

   localparam int CNT_NBIT = $clog2(P_SETTLE + P_CHECK + 3);

   localparam logic [CNT_NBIT-1:0]     CNT_ONE     = CNT_NBIT'(1);
   localparam logic [CNT_NBIT-1:0]     CNT_STROBE  = CNT_NBIT'(2);
   localparam logic [CNT_NBIT-1:0]     CNT_WR_END  = CNT_NBIT'(1);
   localparam logic [CNT_NBIT-1:0]     CNT_SET_END = CNT_NBIT'(P_SETTLE - 1);
   localparam logic [CNT_NBIT-1:0]     CNT_CHK_END = CNT_NBIT'(P_CHECK - 1);
   localparam logic [CNT_NBIT-1:0]     CNT_APP_END = CNT_NBIT'(P_SETTLE + 1);
   localparam logic [P_DELAY_NBIT-1:0] TAP_ONE     = P_DELAY_NBIT'(1);
   localparam logic [P_DELAY_NBIT-1:0] TAP_LAST    = {P_DELAY_NBIT{1'b1}};
   localparam logic [P_DELAY_NBIT:0]   LEN_ONE     = (P_DELAY_NBIT + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_SETTLE,
      S_CHECK,
      S_NEXT,
      S_APPLY,
      S_DONE
   } state_t;

   state_t                  state_q,      state_d;
   logic [CNT_NBIT-1:0]     cnt_q,        cnt_d;
   logic [P_DELAY_NBIT-1:0] tap_q,        tap_d;
   logic [P_DELAY_NBIT-1:0] delay_q,      delay_d;
   logic [P_DELAY_NBIT-1:0] restore_q,    restore_d;
   logic                    bad_q,        bad_d;
   logic [P_DELAY_NBIT:0]   run_len_q,    run_len_d;
   logic [P_DELAY_NBIT-1:0] run_start_q,  run_start_d;
   logic [P_DELAY_NBIT:0]   best_len_q,   best_len_d;
   logic [P_DELAY_NBIT-1:0] best_start_q, best_start_d;
   logic                    fail_q,       fail_d;
   logic [P_DELAY_NBIT-1:0] win_start_q,  win_start_d;
   logic [P_DELAY_NBIT:0]   win_len_q,    win_len_d;
   logic [P_DELAY_NBIT:0]   final_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         tap_q        <= '0;
         delay_q      <= '0;
         restore_q    <= '0;
         bad_q        <= 1'b0;
         run_len_q    <= '0;
         run_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         fail_q       <= 1'b0;
         win_start_q  <= '0;
         win_len_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tap_q        <= tap_d;
         delay_q      <= delay_d;
         restore_q    <= restore_d;
         bad_q        <= bad_d;
         run_len_q    <= run_len_d;
         run_start_q  <= run_start_d;
         best_len_q   <= best_len_d;
         best_start_q <= best_start_d;
         fail_q       <= fail_d;
         win_start_q  <= win_start_d;
         win_len_q    <= win_len_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tap_d        = tap_q;
      delay_d      = delay_q;
      restore_d    = restore_q;
      bad_d        = bad_q;
      run_len_d    = run_len_q;
      run_start_d  = run_start_q;
      best_len_d   = best_len_q;
      best_start_d = best_start_q;
      fail_d       = fail_q;
      win_start_d  = win_start_q;
      win_len_d    = win_len_q;
      final_sum    = '0;

      unique case (state_q)
         S_IDLE: begin
            if (in_start) begin
               state_d      = S_WRITE;
               cnt_d        = '0;
               tap_d        = '0;
               delay_d      = '0;
               restore_d    = delay_q;
               run_len_d    = '0;
               run_start_d  = '0;
               best_len_d   = '0;
               best_start_d = '0;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_WR_END) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + CNT_ONE;
            bad_d = 1'b0;
            if (cnt_q == CNT_SET_END) begin
               state_d = S_CHECK;
               cnt_d   = '0;
            end
         end
         S_CHECK: begin
            cnt_d = cnt_q + CNT_ONE;
            bad_d = bad_q | (in_dio != in_pattern);
            if (cnt_q == CNT_CHK_END) begin
               state_d = S_NEXT;
               cnt_d   = '0;
            end
         end
         S_NEXT: begin
            // NOTE: the run/best updates below read earlier _d assignments of this same
            // block, so the whole window bookkeeping settles within the one NEXT cycle.
            if (!bad_q) begin
               run_len_d = run_len_q + LEN_ONE;
               if (run_len_q == '0) run_start_d = tap_q;
            end
            if (bad_q || (tap_q == TAP_LAST)) begin
               if (run_len_d > best_len_q) begin
                  best_len_d   = run_len_d;
                  best_start_d = run_start_d;
               end
               run_len_d = '0;
            end
            if (tap_q == TAP_LAST) begin
               state_d   = S_APPLY;
               final_sum = {1'b0, best_start_d} + ((best_len_d - LEN_ONE) >> 1);
               delay_d   = (best_len_d == '0) ? restore_q : final_sum[P_DELAY_NBIT-1:0];
            end else begin
               state_d = S_WRITE;
               tap_d   = tap_q + TAP_ONE;
               delay_d = tap_q + TAP_ONE;
            end
         end
         S_APPLY: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_APP_END) begin
               state_d     = S_DONE;
               cnt_d       = '0;
               win_start_d = best_start_q;
               win_len_d   = best_len_q;
               fail_d      = (best_len_q == '0);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobe and status are decoded from the registered state, so they clear with rst too.
   assign out_delay     = delay_q;
   assign out_delay_we  = (state_q == S_WRITE) || ((state_q == S_APPLY) && (cnt_q < CNT_STROBE));
   assign out_busy      = (state_q != S_IDLE);
   assign out_done      = (state_q == S_DONE);
   assign out_fail      = fail_q;
   assign out_win_start = win_start_q;
   assign out_win_len   = win_len_q;

endmodule

// File: tb/tb_iodelay_cal.sv
// Directed bench for iodelay_cal: a delay-line model passes only at the listed taps,
// and a negedge monitor checks the tap-write strobe protocol and records every written tap.
module tb_iodelay_cal;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_start = 1'b0;
   logic [0:0]  in_pattern = 1'b1;
   logic [0:0]  in_dio;
   logic [4:0]  out_delay;
   logic        out_delay_we;
   logic        out_busy;
   logic        out_done;
   logic        out_fail;
   logic [4:0]  out_win_start;
   logic [5:0]  out_win_len;

   logic [31:0] pass_mask = '0;

   int n_checks = 0;
   int n_errors = 0;

   localparam int RUN_CYCLES = 1 + 32 * 75 + 10;

   iodelay_cal #(
      .P_DATA_NBIT (1),
      .P_DELAY_NBIT(5),
      .P_SETTLE    (8),
      .P_CHECK     (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_start     (in_start),
      .in_pattern   (in_pattern),
      .in_dio       (in_dio),
      .out_delay    (out_delay),
      .out_delay_we (out_delay_we),
      .out_busy     (out_busy),
      .out_done     (out_done),
      .out_fail     (out_fail),
      .out_win_start(out_win_start),
      .out_win_len  (out_win_len)
   );

   always #5 clk = ~clk;

   // Delay-line model: the lane reads back correctly only at taps set in pass_mask.
   assign in_dio = pass_mask[out_delay] ? in_pattern : ~in_pattern;

   int         hi_cnt    = 0;
   int         lo_cnt    = 100;
   int         proto_err = 0;
   int         done_cnt  = 0;
   logic       prev_we   = 1'b0;
   logic [4:0] prev_delay = '0;
   logic [4:0] writes[$];

   always @(negedge clk) begin
      if (out_done) done_cnt++;
      if (out_delay_we) begin
         if (!prev_we) begin
            if (lo_cnt < 3) proto_err++;
            hi_cnt = 1;
            writes.push_back(out_delay);
         end else begin
            hi_cnt++;
            if (out_delay != prev_delay) proto_err++;
         end
      end else begin
         if (prev_we) begin
            if (hi_cnt != 2) proto_err++;
            lo_cnt = 1;
         end else begin
            lo_cnt++;
         end
         if ((out_delay != prev_delay) && (lo_cnt <= 3)) proto_err++;
      end
      prev_we    = out_delay_we;
      prev_delay = out_delay;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_cal(input string tag, input logic [31:0] mask, input int exp_start,
                          input int exp_len, input int exp_final, input bit exp_fail);
      int  n;
      int  base;
      int  err0;
      int  d0;
      bit  seq_ok;
      pass_mask = mask;
      base = writes.size();
      err0 = proto_err;
      d0   = done_cnt;
      @(negedge clk);
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
      n = 1;
      check({tag, " busy"}, 32'(out_busy), 32'd1);
      while (!out_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done_cycle"}, 32'(n), 32'(RUN_CYCLES));
      check({tag, " win_start"}, 32'(out_win_start), 32'(exp_start));
      check({tag, " win_len"}, 32'(out_win_len), 32'(exp_len));
      check({tag, " fail"}, 32'(out_fail), 32'(exp_fail));
      check({tag, " final_tap"}, 32'(out_delay), 32'(exp_final));
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(out_done), 32'd0);
      repeat (5) @(negedge clk);
      check({tag, " idle_hold"}, 32'(out_delay), 32'(exp_final));
      check({tag, " idle_busy"}, 32'(out_busy), 32'd0);
      check({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
      seq_ok = (writes.size() == base + 33);
      if (seq_ok) begin
         for (int i = 0; i < 32; i++)
            if (writes[base + i] != 5'(i)) seq_ok = 1'b0;
         if (writes[base + 32] != 5'(exp_final)) seq_ok = 1'b0;
      end
      check({tag, " write_seq"}, 32'(seq_ok), 32'd1);
      check({tag, " strobe_proto"}, 32'(proto_err - err0), 32'd0);
   endtask

   initial begin
      int n;
      int d0;
      #12;
      check("rst delay", 32'(out_delay), 32'd0);
      check("rst we", 32'(out_delay_we), 32'd0);
      check("rst busy", 32'(out_busy), 32'd0);
      check("rst done", 32'(out_done), 32'd0);
      check("rst fail", 32'(out_fail), 32'd0);
      check("rst win_len", 32'(out_win_len), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      run_cal("win10_20", 32'h001F_FC00, 10, 11, 15, 1'b0);
      run_cal("two_win", 32'h3FF0_003C, 20, 10, 24, 1'b0);
      in_pattern = 1'b0;
      run_cal("all_pass", 32'hFFFF_FFFF, 0, 32, 15, 1'b0);
      in_pattern = 1'b1;
      run_cal("prime7", 32'h0000_0080, 7, 1, 7, 1'b0);
      run_cal("none", 32'h0000_0000, 0, 0, 7, 1'b1);
      run_cal("tie", 32'h0000_F0F0, 4, 4, 5, 1'b0);

      // Abort during CHECK of tap 9 after an ignored second start request.
      pass_mask = 32'h001F_FC00;
      d0 = done_cnt;
      @(negedge clk);
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
      n = 1;
      while (n < 700) begin
         @(negedge clk);
         n++;
         if (n == 100) in_start = 1'b1;
         if (n == 101) in_start = 1'b0;
      end
      check("abort tap9", 32'(out_delay), 32'd9);
      check("abort busy", 32'(out_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async delay", 32'(out_delay), 32'd0);
      check("async we", 32'(out_delay_we), 32'd0);
      check("async busy", 32'(out_busy), 32'd0);
      check("async win_start", 32'(out_win_start), 32'd0);
      check("async win_len", 32'(out_win_len), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort no_done", 32'(done_cnt - d0), 32'd0);
      check("abort idle", 32'(out_busy), 32'd0);
      run_cal("restart", 32'h001F_FC00, 10, 11, 15, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
